// File: rtl/mem_pkg.sv
// Shared bus definitions: word/address sizes and the bus-master FSM encodings, which the
// CPU bus decoder also uses. ADDR_SIZE/WORD_SIZE can be overridden on the command line.
`ifndef ADDR_SIZE
`define ADDR_SIZE 16
`endif
`ifndef WORD_SIZE
`define WORD_SIZE 16
`endif

package mem_pkg;

  localparam int unsigned ADDR_W = `ADDR_SIZE;
  localparam int unsigned WORD_W = `WORD_SIZE;
  localparam int unsigned CNT_W  = 4;

  localparam logic [1:0] ST_IDLE  = 2'd0;
  localparam logic [1:0] ST_WRITE = 2'd1;
  localparam logic [1:0] ST_READ  = 2'd2;
  localparam logic [1:0] ST_RESP  = 2'd3;

  typedef enum logic [1:0] {
    StIdle  = ST_IDLE,
    StWrite = ST_WRITE,
    StRead  = ST_READ,
    StResp  = ST_RESP
  } state_e;

endpackage

// File: rtl/mem_master.sv
// CPU-side word master on a shared bidirectional memory bus with a valid/ready request
// and response. Define MEM_ALIGN_CHK_EN to add rsp_err and reject odd addresses.
module mem_master
  import mem_pkg::*;
#(
  parameter int unsigned RD_WAIT = 0
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              req_valid,
  output logic              req_ready,
  input  logic              req_we,
  input  logic [ADDR_W-1:0] req_addr,
  input  logic [WORD_W-1:0] req_wdata,
  output logic              rsp_valid,
  input  logic              rsp_ready,
  output logic [WORD_W-1:0] rsp_rdata,
`ifdef MEM_ALIGN_CHK_EN
  output logic              rsp_err,
`endif
  output logic              mem_wr_en,
  output logic [ADDR_W-1:0] mem_addr,
  inout  wire  [WORD_W-1:0] mem_data
);

  state_e             state_q, state_d;
  logic [ADDR_W-1:0]  addr_q, addr_d;
  logic [WORD_W-1:0]  wdata_q, wdata_d;
  logic [WORD_W-1:0]  rdata_q, rdata_d;
  logic [CNT_W-1:0]   cnt_q, cnt_d;
  logic               misaligned;

  localparam logic [CNT_W-1:0] RdWaitInit = CNT_W'(RD_WAIT);

`ifdef MEM_ALIGN_CHK_EN
  logic err_q, err_d;
  assign misaligned = req_addr[0];
  assign rsp_err    = err_q;
`else
  assign misaligned = 1'b0;
`endif

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= StIdle;
      addr_q  <= '0;
      wdata_q <= '0;
      rdata_q <= '0;
      cnt_q   <= '0;
`ifdef MEM_ALIGN_CHK_EN
      err_q   <= 1'b0;
`endif
    end else begin
      state_q <= state_d;
      addr_q  <= addr_d;
      wdata_q <= wdata_d;
      rdata_q <= rdata_d;
      cnt_q   <= cnt_d;
`ifdef MEM_ALIGN_CHK_EN
      err_q   <= err_d;
`endif
    end
  end

  always_comb begin
    state_d = state_q;
    addr_d  = addr_q;
    wdata_d = wdata_q;
    rdata_d = rdata_q;
    cnt_d   = cnt_q;
`ifdef MEM_ALIGN_CHK_EN
    err_d   = err_q;
`endif
    unique case (state_q)
      StIdle: begin
        if (req_valid) begin
          addr_d  = req_addr;
          wdata_d = req_wdata;
`ifdef MEM_ALIGN_CHK_EN
          err_d   = misaligned;
`endif
          // Misaligned requests skip the bus entirely and answer at once.
          if (misaligned) begin
            state_d = StResp;
          end else if (req_we) begin
            state_d = StWrite;
          end else begin
            state_d = StRead;
            cnt_d   = RdWaitInit;
          end
        end
      end
      StWrite: begin
        state_d = StResp;
      end
      StRead: begin
        if (cnt_q == '0) begin
          rdata_d = mem_data;
          state_d = StResp;
        end else begin
          cnt_d = cnt_q - 1'b1;
        end
      end
      StResp: begin
        if (rsp_ready) begin
          state_d = StIdle;
        end
      end
      default: state_d = StIdle;
    endcase
  end

  assign req_ready = (state_q == StIdle);
  assign rsp_valid = (state_q == StResp);
  assign rsp_rdata = rdata_q;
  assign mem_addr  = addr_q;
  assign mem_wr_en = (state_q == StWrite);

  // Driver enable and write strobe come from the same state bit, so the bus never overlaps.
  assign mem_data = mem_wr_en ? wdata_q : {WORD_W{1'bz}};

endmodule

// File: tb/tb_mem_master.sv
// Directed bench: mem_master with RD_WAIT=3 sharing mem_data with a byte-addressed RAM model.
module tb_mem_master;
  import mem_pkg::*;

  localparam int unsigned RdWait = 3;

  logic              clk = 1'b0;
  logic              rst;
  logic              req_valid;
  logic              req_ready;
  logic              req_we;
  logic [ADDR_W-1:0] req_addr;
  logic [WORD_W-1:0] req_wdata;
  logic              rsp_valid;
  logic              rsp_ready;
  logic [WORD_W-1:0] rsp_rdata;
  logic              mem_wr_en;
  logic [ADDR_W-1:0] mem_addr;
  wire  [WORD_W-1:0] mem_data;
`ifdef MEM_ALIGN_CHK_EN
  logic              rsp_err;
`endif

  int n_checks = 0;
  int n_errors = 0;

  // RAM model: little-endian word at mem_addr, high byte wraps past the top address.
  logic [7:0]        ram [2**ADDR_W] = '{default: 8'h00};
  logic [ADDR_W-1:0] ram_hi_addr;
  logic              pre_we = 1'b0;
  logic [ADDR_W-1:0] pre_addr = '0;
  logic [7:0]        pre_data = '0;

  assign ram_hi_addr = mem_addr + 1'b1;
  assign mem_data = mem_wr_en ? {WORD_W{1'bz}} : {ram[ram_hi_addr], ram[mem_addr]};

  always @(posedge clk) begin
    if (pre_we) begin
      ram[pre_addr] <= pre_data;
    end else if (mem_wr_en) begin
      ram[mem_addr]    <= mem_data[7:0];
      ram[ram_hi_addr] <= mem_data[15:8];
    end
  end

  always #5 clk = ~clk;

  mem_master #(
    .RD_WAIT(RdWait)
  ) dut (
    .clk      (clk),
    .rst      (rst),
    .req_valid(req_valid),
    .req_ready(req_ready),
    .req_we   (req_we),
    .req_addr (req_addr),
    .req_wdata(req_wdata),
    .rsp_valid(rsp_valid),
    .rsp_ready(rsp_ready),
    .rsp_rdata(rsp_rdata),
`ifdef MEM_ALIGN_CHK_EN
    .rsp_err  (rsp_err),
`endif
    .mem_wr_en(mem_wr_en),
    .mem_addr (mem_addr),
    .mem_data (mem_data)
  );

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_errors++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Present one request from IDLE; lat counts edges from acceptance until rsp_valid.
  task automatic issue(input logic we, input logic [ADDR_W-1:0] a, input logic [WORD_W-1:0] d,
                       output int lat, output logic wr_seen);
    req_valid = 1'b1;
    req_we    = we;
    req_addr  = a;
    req_wdata = d;
    lat       = 0;
    wr_seen   = 1'b0;
    do begin
      tick();
      lat++;
      req_valid = 1'b0;
      if (mem_wr_en) wr_seen = 1'b1;
    end while (!rsp_valid && lat < 40);
  endtask

  task automatic ack();
    rsp_ready = 1'b1;
    tick();
    rsp_ready = 1'b0;
  endtask

  int   lat;
  logic wr_seen;

  initial begin
    rst       = 1'b1;
    req_valid = 1'b0;
    req_we    = 1'b0;
    req_addr  = '0;
    req_wdata = '0;
    rsp_ready = 1'b0;

    // Preload 0x1234 at 0x0020 while held in reset.
    tick();
    pre_we = 1'b1; pre_addr = 16'h0020; pre_data = 8'h34;
    tick();
    pre_addr = 16'h0021; pre_data = 8'h12;
    tick();
    pre_we = 1'b0;

    check("rst_req_ready", req_ready, 1);
    check("rst_rsp_valid", rsp_valid, 0);
    check("rst_rsp_rdata", rsp_rdata, 0);
    check("rst_mem_addr", mem_addr, 0);
    check("rst_mem_wr_en", mem_wr_en, 0);
    rst = 1'b0;

    // Write 0xBEEF to 0x0010, stepping cycle by cycle.
    req_valid = 1'b1; req_we = 1'b1; req_addr = 16'h0010; req_wdata = 16'hBEEF;
    tick();
    req_valid = 1'b0;
    check("wr_cyc_wr_en", mem_wr_en, 1);
    check("wr_cyc_addr", mem_addr, 16'h0010);
    check("wr_cyc_data", mem_data, 16'hBEEF);
    check("wr_cyc_req_ready", req_ready, 0);
    check("wr_cyc_rsp_valid", rsp_valid, 0);
    tick();
    check("wr_rsp_valid", rsp_valid, 1);
    check("wr_rsp_wr_en", mem_wr_en, 0);
    check("wr_ram_lo", ram[16'h0010], 8'hEF);
    check("wr_ram_hi", ram[16'h0011], 8'hBE);
    ack();
    check("wr_ack_idle", req_ready, 1);
    check("wr_ack_rsp_valid", rsp_valid, 0);

    // Read back 0x0010.
    issue(1'b0, 16'h0010, 16'h0000, lat, wr_seen);
    check("rd10_lat", lat, RdWait + 2);
    check("rd10_wr_seen", wr_seen, 0);
    check("rd10_data", rsp_rdata, 16'hBEEF);
    ack();

    // Preloaded read with RD_WAIT=3, then a stalled response.
    issue(1'b0, 16'h0020, 16'h0000, lat, wr_seen);
    check("rd20_lat", lat, 5);
    check("rd20_data", rsp_rdata, 16'h1234);
    req_valid = 1'b1; req_we = 1'b1; req_addr = 16'h0030; req_wdata = 16'h7777;
    for (int i = 0; i < 4; i++) begin
      tick();
      check("hold_rsp_valid", rsp_valid, 1);
      check("hold_rsp_rdata", rsp_rdata, 16'h1234);
      check("hold_req_ready", req_ready, 0);
      check("hold_wr_en", mem_wr_en, 0);
    end
    req_valid = 1'b0;
    ack();
    check("hold_ack_idle", req_ready, 1);
    check("hold_ack_rsp_valid", rsp_valid, 0);
    check("hold_ram_untouched", ram[16'h0030], 8'h00);

    // Reset asserted during the WRITE cycle, before its closing edge.
    req_valid = 1'b1; req_we = 1'b1; req_addr = 16'h0040; req_wdata = 16'h5A5A;
    tick();
    req_valid = 1'b0;
    check("rstw_wr_en_before", mem_wr_en, 1);
    #2;
    rst = 1'b1;
    #1;
    check("rstw_wr_en", mem_wr_en, 0);
    check("rstw_bus_released", mem_data, 16'h0000);
    check("rstw_mem_addr", mem_addr, 0);
    check("rstw_rsp_valid", rsp_valid, 0);
    tick();
    rst = 1'b0;
    check("rstw_ram_lo", ram[16'h0040], 8'h00);
    check("rstw_ram_hi", ram[16'h0041], 8'h00);
    check("rstw_req_ready", req_ready, 1);
    issue(1'b0, 16'h0010, 16'h0000, lat, wr_seen);
    check("rstw_next_lat", lat, 5);
    check("rstw_next_data", rsp_rdata, 16'hBEEF);
    ack();

`ifdef MEM_ALIGN_CHK_EN
    // Misaligned read is answered with an error and no bus cycle.
    issue(1'b0, 16'h0011, 16'h0000, lat, wr_seen);
    check("mis_lat", lat, 1);
    check("mis_err", rsp_err, 1);
    check("mis_wr_seen", wr_seen, 0);
    check("mis_rdata_kept", rsp_rdata, 16'hBEEF);
    ack();
    issue(1'b0, 16'h0020, 16'h0000, lat, wr_seen);
    check("al_lat", lat, 5);
    check("al_err", rsp_err, 0);
    check("al_rdata", rsp_rdata, 16'h1234);
    ack();
`else
    // All-ones address: the high byte wraps to byte 0.
    issue(1'b1, 16'hFFFF, 16'hA55A, lat, wr_seen);
    check("wrap_wr_lat", lat, 2);
    check("wrap_wr_seen", wr_seen, 1);
    check("wrap_mem_addr", mem_addr, 16'hFFFF);
    check("wrap_ram_top", ram[16'hFFFF], 8'h5A);
    check("wrap_ram_zero", ram[16'h0000], 8'hA5);
    ack();
    check("wrap_idle_addr_hold", mem_addr, 16'hFFFF);
    issue(1'b0, 16'hFFFF, 16'h0000, lat, wr_seen);
    check("wrap_rd_lat", lat, 5);
    check("wrap_rd_data", rsp_rdata, 16'hA55A);
    ack();
    // Odd address is serviced normally without the alignment check.
    issue(1'b0, 16'h0011, 16'h0000, lat, wr_seen);
    check("odd_rd_lat", lat, 5);
    check("odd_rd_data", rsp_rdata, 16'h00BE);
    ack();
`endif

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
